plot_arbiter: RTL and testbench

PLOT_ARBITER -- requirements
Module: plot_arbiter

---
 rtl/plot_arbiter_pkg.sv | 39 +++
 rtl/plot_arbiter_rr.sv | 39 +++
 rtl/plot_arbiter.sv | 141 ++++++++++++++
 tb/tb_plot_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/plot_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// plot_arbiter_pkg
// Shared definitions for the plot arbiter: screen/colour widths (as macros,
// visible to every file compiled after this one), requester count, FSM state
// encoding and the round-robin pointer helper.
// No ports (package).
// ---------------------------------------------------------------------------
`ifndef PLOT_ARBITER_DEFS
`define PLOT_ARBITER_DEFS
`define SCR_WIDTH_BITS  8
`define SCR_HEIGHT_BITS 7
`define COLOR_SIZE      3
`endif

package plot_arbiter_pkg;

   localparam int NUM_REQ = 3;
   localparam int XW      = `SCR_WIDTH_BITS;
   localparam int YW      = `SCR_HEIGHT_BITS;
   localparam int CW      = `COLOR_SIZE;

   typedef enum logic {
      ST_SERVE = 1'b0,
      ST_CLEAR = 1'b1
   } plot_state_e;

   // Pointer names the requester with highest priority next cycle:
   // the one after the requester just granted.
   function automatic logic [1:0] rr_next_ptr(input logic [NUM_REQ-1:0] grant);
      logic [1:0] nxt;
      case (grant)
         3'b001:  nxt = 2'd1;
         3'b010:  nxt = 2'd2;
         default: nxt = 2'd0;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/plot_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter3
// Combinational three-way round-robin selector.
// Ports:
//   i_req   [2:0] request vector, bit i = requester i
//   i_ptr   [1:0] index of the requester with highest priority (0..2)
//   o_grant [2:0] one-hot grant, all zero when no request is asserted
// ---------------------------------------------------------------------------
module rr_arbiter3
   import plot_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [1:0]         i_ptr,
   output logic [NUM_REQ-1:0] o_grant
);

   always_comb begin
      o_grant = '0;
      case (i_ptr)
         2'd1: begin
            if      (i_req[1]) o_grant = 3'b010;
            else if (i_req[2]) o_grant = 3'b100;
            else if (i_req[0]) o_grant = 3'b001;
         end
         2'd2: begin
            if      (i_req[2]) o_grant = 3'b100;
            else if (i_req[0]) o_grant = 3'b001;
            else if (i_req[1]) o_grant = 3'b010;
         end
         // Pointer value 3 never occurs; treat it like 0.
         default: begin
            if      (i_req[0]) o_grant = 3'b001;
            else if (i_req[1]) o_grant = 3'b010;
            else if (i_req[2]) o_grant = 3'b100;
         end
      endcase
   end

endmodule

// File: rtl/plot_arbiter.sv
// ---------------------------------------------------------------------------
// plot_arbiter
// Arbitrates three pixel-plot requesters onto one framebuffer write port and
// performs full-screen clears by sweeping every pixel with CLEAR_COLOR.
// Ports:
//   Clck        clock, rising edge
//   Reset       asynchronous active-low reset
//   req         per-requester plot request
//   req_x/y     packed coordinates, slice i = requester i
//   req_color   packed colours, slice i = requester i
//   grant       one-hot acknowledge; data is captured in the granted cycle
//   clear_req   single-cycle clear request
//   clear_busy  high while the clear sweep runs
//   plot_x/y, plot_color, plot  registered framebuffer write port
// ---------------------------------------------------------------------------
module plot_arbiter
   import plot_arbiter_pkg::*;
#(
   parameter int                     SCR_W       = 160,
   parameter int                     SCR_H       = 120,
   parameter logic [`COLOR_SIZE-1:0] CLEAR_COLOR = 3'b000
) (
   input  logic                          Clck,
   input  logic                          Reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [3*`SCR_WIDTH_BITS-1:0]  req_x,
   input  logic [3*`SCR_HEIGHT_BITS-1:0] req_y,
   input  logic [3*`COLOR_SIZE-1:0]      req_color,
   output logic [NUM_REQ-1:0]            grant,
   input  logic                          clear_req,
   output logic                          clear_busy,
   output logic [`SCR_WIDTH_BITS-1:0]    plot_x,
   output logic [`SCR_HEIGHT_BITS-1:0]   plot_y,
   output logic [`COLOR_SIZE-1:0]        plot_color,
   output logic                          plot
);

   localparam logic [XW-1:0] X_LAST = XW'(SCR_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(SCR_H - 1);

   plot_state_e        r_state;
   logic [1:0]         r_ptr;
   logic [XW-1:0]      r_x_cnt;
   logic [YW-1:0]      r_y_cnt;

   logic               r_vld_p1;
   logic [XW-1:0]      r_plot_x_p1;
   logic [YW-1:0]      r_plot_y_p1;
   logic [CW-1:0]      r_plot_color_p1;

   logic [NUM_REQ-1:0] w_rr_grant;
   logic [NUM_REQ-1:0] w_grant;
   logic [XW-1:0]      w_sel_x_p0;
   logic [YW-1:0]      w_sel_y_p0;
   logic [CW-1:0]      w_sel_color_p0;

   rr_arbiter3 u_rr (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_grant (w_rr_grant)
   );

   // Grant is combinational so a request can be acknowledged in the cycle it
   // is presented. A simultaneous clear_req wins, and reset silences it.
   assign w_grant = (Reset && (r_state == ST_SERVE) && !clear_req) ? w_rr_grant : '0;

   always_comb begin
      w_sel_x_p0     = req_x[0 +: XW];
      w_sel_y_p0     = req_y[0 +: YW];
      w_sel_color_p0 = req_color[0 +: CW];
      case (w_grant)
         3'b010: begin
            w_sel_x_p0     = req_x[XW +: XW];
            w_sel_y_p0     = req_y[YW +: YW];
            w_sel_color_p0 = req_color[CW +: CW];
         end
         3'b100: begin
            w_sel_x_p0     = req_x[2*XW +: XW];
            w_sel_y_p0     = req_y[2*YW +: YW];
            w_sel_color_p0 = req_color[2*CW +: CW];
         end
         default: ;
      endcase
   end

   // ---- p0 -> p1: granted request or sweep pixel registered onto the port ----
   always_ff @(posedge Clck or negedge Reset) begin
      if (!Reset) begin
         r_state         <= ST_SERVE;
         r_ptr           <= 2'd0;
         r_x_cnt         <= '0;
         r_y_cnt         <= '0;
         r_vld_p1        <= 1'b0;
         r_plot_x_p1     <= '0;
         r_plot_y_p1     <= '0;
         r_plot_color_p1 <= '0;
      end else begin
         r_vld_p1 <= 1'b0;
         unique case (r_state)
            ST_SERVE: begin
               if (clear_req) begin
                  r_state <= ST_CLEAR;
               end else if (|w_grant) begin
                  r_vld_p1        <= 1'b1;
                  r_plot_x_p1     <= w_sel_x_p0;
                  r_plot_y_p1     <= w_sel_y_p0;
                  r_plot_color_p1 <= w_sel_color_p0;
                  r_ptr           <= rr_next_ptr(w_grant);
               end
            end
            ST_CLEAR: begin
               r_vld_p1        <= 1'b1;
               r_plot_x_p1     <= r_x_cnt;
               r_plot_y_p1     <= r_y_cnt;
               r_plot_color_p1 <= CLEAR_COLOR;
               // Counters wrap exactly at the last coordinate; leaving the
               // sweep with both at 0 readies them for the next clear.
               if (r_x_cnt == X_LAST) begin
                  r_x_cnt <= '0;
                  if (r_y_cnt == Y_LAST) begin
                     r_y_cnt <= '0;
                     r_state <= ST_SERVE;
                  end else begin
                     r_y_cnt <= r_y_cnt + 1'b1;
                  end
               end else begin
                  r_x_cnt <= r_x_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   assign grant      = w_grant;
   assign clear_busy = (r_state == ST_CLEAR);
   assign plot       = r_vld_p1;
   assign plot_x     = r_plot_x_p1;
   assign plot_y     = r_plot_y_p1;
   assign plot_color = r_plot_color_p1;

endmodule

// File: tb/tb_plot_arbiter.sv
module tb_plot_arbiter;
   import plot_arbiter_pkg::*;

   logic                  Clck = 1'b0;
   logic                  Reset;
   logic [NUM_REQ-1:0]    req;
   logic [3*XW-1:0]       req_x;
   logic [3*YW-1:0]       req_y;
   logic [3*CW-1:0]       req_color;
   logic [NUM_REQ-1:0]    grant;
   logic                  clear_req;
   logic                  clear_busy;
   logic [XW-1:0]         plot_x;
   logic [YW-1:0]         plot_y;
   logic [CW-1:0]         plot_color;
   logic                  plot;

   int n_chk  = 0;
   int n_fail = 0;
   int pix, mx, my, px_err, busy, gerr, plots;

   always #5 Clck = ~Clck;

   plot_arbiter dut (
      .Clck       (Clck),
      .Reset      (Reset),
      .req        (req),
      .req_x      (req_x),
      .req_y      (req_y),
      .req_color  (req_color),
      .grant      (grant),
      .clear_req  (clear_req),
      .clear_busy (clear_busy),
      .plot_x     (plot_x),
      .plot_y     (plot_y),
      .plot_color (plot_color),
      .plot       (plot)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input int x, input int y, input int c);
      req_x[i*XW +: XW]     = XW'(x);
      req_y[i*YW +: YW]     = YW'(y);
      req_color[i*CW +: CW] = CW'(c);
   endtask

   task automatic next_cycle;
      @(posedge Clck);
      #1;
   endtask

   // Expected sweep order: x inner 0..159, y outer 0..119, colour 0.
   task automatic sample_pixel;
      if (plot_x !== XW'(mx) || plot_y !== YW'(my) || plot_color !== '0) px_err++;
      if (pix == 0) begin
         chk("px0_x", plot_x, 0);
         chk("px0_y", plot_y, 0);
      end
      if (pix == 160) begin
         chk("px160_x", plot_x, 0);
         chk("px160_y", plot_y, 1);
      end
      if (pix == 19199) begin
         chk("pxlast_x", plot_x, 159);
         chk("pxlast_y", plot_y, 119);
         chk("pxlast_color", plot_color, 0);
      end
      pix++;
      mx++;
      if (mx == 160) begin
         mx = 0;
         my++;
         if (my == 120) my = 0;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b0; req = '0; req_x = '0; req_y = '0; req_color = '0; clear_req = 1'b0;
      repeat (2) @(posedge Clck);
      #1 req = 3'b001;
      @(negedge Clck);
      chk("rst_grant", grant, 0);
      chk("rst_plot", plot, 0);
      chk("rst_busy", clear_busy, 0);
      chk("rst_x", plot_x, 0);
      chk("rst_y", plot_y, 0);
      chk("rst_color", plot_color, 0);

      // Fairness: all three requesting, grants must rotate from requester 0.
      next_cycle();
      Reset = 1'b1;
      req   = 3'b111;
      set_req(0, 1, 11, 1);
      set_req(1, 2, 12, 2);
      set_req(2, 3, 13, 3);
      plots = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge Clck);
         chk($sformatf("rr_grant%0d", k), grant, 32'd1 << (k % 3));
         if (plot) plots++;
         if (k > 0) chk($sformatf("rr_px%0d", k), plot_x, (k - 1) % 3 + 1);
         next_cycle();
      end
      req = '0;
      @(negedge Clck);
      if (plot) plots++;
      chk("rr_px_last", plot_x, 3);
      chk("rr_py_last", plot_y, 13);
      next_cycle();
      @(negedge Clck);
      if (plot) plots++;
      chk("idle_plot", plot, 0);
      chk("rr_plot_count", plots, 6);

      // Latency: requester 1 alone.
      next_cycle();
      req = 3'b010;
      set_req(1, 10, 20, 5);
      @(negedge Clck);
      chk("lat_grant", grant, 3'b010);
      chk("lat_plot_T", plot, 0);
      next_cycle();
      req = '0;
      @(negedge Clck);
      chk("lat_plot", plot, 1);
      chk("lat_x", plot_x, 10);
      chk("lat_y", plot_y, 20);
      chk("lat_color", plot_color, 5);

      // Pointer now favours requester 2 over 0.
      next_cycle();
      req = 3'b101;
      set_req(0, 30, 40, 6);
      set_req(2, 50, 60, 7);
      @(negedge Clck);
      chk("rr2_grant", grant, 3'b100);
      next_cycle();
      req = 3'b001;
      @(negedge Clck);
      chk("rr0_grant", grant, 3'b001);
      chk("rr2_px", plot_x, 50);
      chk("rr2_color", plot_color, 7);
      next_cycle();
      req = '0;
      @(negedge Clck);
      chk("rr0_px", plot_x, 30);
      chk("rr0_color", plot_color, 6);

      // Collision: clear wins; the waiting request resumes after the sweep.
      // A second clear_req mid-sweep must not lengthen it.
      next_cycle();
      req = 3'b001;
      set_req(0, 77, 88, 4);
      clear_req = 1'b1;
      @(negedge Clck);
      chk("coll_grant", grant, 0);
      chk("coll_busy_T", clear_busy, 0);
      next_cycle();
      clear_req = 1'b0;
      busy = 0; pix = 0; mx = 0; my = 0; px_err = 0; gerr = 0;
      for (int c = 0; c < 25000; c++) begin
         @(negedge Clck);
         if (plot) sample_pixel();
         if (!clear_busy) break;
         busy++;
         if (grant != '0) gerr++;
         next_cycle();
         clear_req = (pix == 100);
      end
      chk("clear_busy_cycles", busy, 19200);
      chk("clear_pixels", pix, 19200);
      chk("clear_pixels_bad", px_err, 0);
      chk("clear_grants", gerr, 0);
      chk("resume_grant", grant, 3'b001);
      next_cycle();
      req = '0;
      @(negedge Clck);
      chk("resume_plot", plot, 1);
      chk("resume_x", plot_x, 77);
      chk("resume_y", plot_y, 88);
      chk("resume_color", plot_color, 4);

      // Reset in the middle of a sweep.
      next_cycle();
      clear_req = 1'b1;
      next_cycle();
      clear_req = 1'b0;
      pix = 0; mx = 0; my = 0; px_err = 0;
      for (int c = 0; c < 10000; c++) begin
         @(negedge Clck);
         if (plot) sample_pixel();
         if (pix == 5000) break;
         next_cycle();
      end
      chk("pre_reset_pixels", pix, 5000);
      chk("pre_reset_bad", px_err, 0);
      next_cycle();
      Reset = 1'b0;
      #1;
      chk("mid_rst_plot", plot, 0);
      chk("mid_rst_busy", clear_busy, 0);
      chk("mid_rst_grant", grant, 0);
      chk("mid_rst_x", plot_x, 0);
      chk("mid_rst_y", plot_y, 0);
      chk("mid_rst_color", plot_color, 0);
      repeat (2) @(posedge Clck);
      #1 Reset = 1'b1;
      plots = 0; busy = 0;
      repeat (20) begin
         @(negedge Clck);
         if (plot) plots++;
         if (clear_busy) busy++;
      end
      chk("post_rst_plots", plots, 0);
      chk("post_rst_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
